// File: rtl/coef_shift_add_seq_if.sv
// rtl/coef_shift_add_seq_if.sv - operand/result valid-ready handshake bundle
interface coef_shift_add_seq_if #(
    parameter int WIDTH = 41
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/coef_shift_add_seq.sv
// rtl/coef_shift_add_seq.sv - time-multiplexed shift-add coefficient multiplier
module coef_shift_add_seq #(
    parameter int WIDTH  = 41,
    parameter int NTERMS = 8,
    parameter int NCOEF  = 4,
    parameter int SHW    = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    coef_shift_add_seq_if.slave io,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_sel,
    input  logic [2:0]      cfg_term,
    input  logic            cfg_en,
    input  logic            cfg_neg,
    input  logic [SHW-1:0]  cfg_shift,
    output logic            busy
);
    localparam int CW = $clog2(NTERMS);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                  state;
    logic signed [WIDTH-1:0] op;
    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] term;
    logic signed [WIDTH-1:0] acc_next;
    logic [SHW-1:0]          sh;
    logic [1:0]              sel;
    logic [CW-1:0]           cnt;
    logic                    out_valid_r;
    logic                    in_ready_r;
    logic [WIDTH-1:0]        out_data_r;

    logic [NTERMS-1:0]       en_r    [NCOEF];
    logic [NTERMS-1:0]       neg_r   [NCOEF];
    logic [SHW-1:0]          shift_r [NCOEF][NTERMS];

    // Power-on coefficient for set 0: 1 + 1/4 + 1/8 + 1/16 + 1/64
    function automatic logic [SHW-1:0] def_shift(input int t);
        case (t)
            1:       return SHW'(2);
            2:       return SHW'(3);
            3:       return SHW'(4);
            4:       return SHW'(6);
            default: return '0;
        endcase
    endfunction

    assign io.out_valid = out_valid_r;
    assign io.out_data  = out_data_r;
    assign io.in_ready  = in_ready_r;

    always_comb begin
        sh = shift_r[sel][cnt];
        // Shifting past the word leaves only sign bits (floor toward -inf)
        if (int'(sh) >= WIDTH)
            term = {WIDTH{op[WIDTH-1]}};
        else
            term = op >>> sh;
        acc_next = acc;
        if (en_r[sel][cnt])
            acc_next = neg_r[sel][cnt] ? acc - term : acc + term;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op          <= '0;
            sel         <= '0;
            acc         <= '0;
            cnt         <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            in_ready_r  <= 1'b1;
            busy        <= 1'b0;
            for (int c = 0; c < NCOEF; c++) begin
                for (int t = 0; t < NTERMS; t++) begin
                    en_r[c][t]    <= (c == 0) && (t < 5);
                    neg_r[c][t]   <= 1'b0;
                    shift_r[c][t] <= (c == 0) ? def_shift(t) : '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        op         <= io.in_data;
                        sel        <= io.in_sel;
                        acc        <= '0;
                        cnt        <= '0;
                        state      <= ACC;
                        in_ready_r <= 1'b0;
                        busy       <= 1'b1;
                    end else if (cfg_we) begin
                        en_r[cfg_sel][cfg_term]    <= cfg_en;
                        neg_r[cfg_sel][cfg_term]   <= cfg_neg;
                        shift_r[cfg_sel][cfg_term] <= cfg_shift;
                    end
                end
                ACC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NTERMS - 1)) begin
                        state       <= DONE;
                        out_data_r  <= acc_next;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                        in_ready_r  <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coef_shift_add_seq.sv
// tb/tb_coef_shift_add_seq.sv - directed self-checking bench for coef_shift_add_seq
module tb_coef_shift_add_seq;
    localparam int WIDTH = 41;
    localparam logic signed [WIDTH-1:0] OVF_IN  = 41'sd1099511627775;
    localparam logic signed [WIDTH-1:0] OVF_EXP = -41'sd601295421445;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cfg_we;
    logic [1:0]     cfg_sel;
    logic [2:0]     cfg_term;
    logic           cfg_en;
    logic           cfg_neg;
    logic [5:0]     cfg_shift;
    logic           busy;
    int             errors = 0;
    int             checks = 0;

    always #5 clk = ~clk;

    coef_shift_add_seq_if #(.WIDTH(WIDTH)) io ();

    coef_shift_add_seq #(.WIDTH(WIDTH), .NTERMS(8), .NCOEF(4), .SHW(6)) dut (
        .clk(clk), .rst_n(rst_n), .io(io),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_term(cfg_term),
        .cfg_en(cfg_en), .cfg_neg(cfg_neg), .cfg_shift(cfg_shift), .busy(busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic signed [WIDTH-1:0] d, input logic [1:0] s,
                         output logic signed [WIDTH-1:0] res, output int lat);
        int w = 0;
        while (!io.in_ready && w < 50) begin step(); w++; end
        io.in_valid = 1'b1; io.in_data = d; io.in_sel = s;
        step();
        io.in_valid = 1'b0;
        lat = 0;
        while (!io.out_valid && lat < 50) begin step(); lat++; end
        res = io.out_data;
        if (io.out_ready) step();
    endtask

    task automatic cfg_write(input logic [1:0] s, input logic [2:0] t, input logic en,
                             input logic neg, input logic [5:0] sh);
        cfg_we = 1'b1; cfg_sel = s; cfg_term = t; cfg_en = en; cfg_neg = neg; cfg_shift = sh;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic wait_result(output logic signed [WIDTH-1:0] res);
        int n = 0;
        while (!io.out_valid && n < 50) begin step(); n++; end
        res = io.out_data;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; io.in_valid = 1'b0; io.in_data = '0; io.in_sel = '0; io.out_ready = 1'b1;
        cfg_we = 1'b0; cfg_sel = '0; cfg_term = '0; cfg_en = 1'b0; cfg_neg = 1'b0; cfg_shift = '0;
        repeat (3) step();
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", io.out_valid); end
        checks++; if (io.out_data !== '0) begin errors++; $display("FAIL reset_out_data got %0d want 0", io.out_data); end
        checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", io.in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic;
        logic signed [WIDTH-1:0] r; int lat;
        do_op(64, 0, r, lat);
        checks++; if (r !== 41'sd93) begin errors++; $display("FAIL basic_64 got %0d want 93", r); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
        checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_after got %b want 1", io.in_ready); end
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid_after got %b want 0", io.out_valid); end
        checks++; if (io.out_data !== 41'sd93) begin errors++; $display("FAIL basic_out_data_kept got %0d want 93", io.out_data); end
    endtask

    task automatic test_neg_floor;
        logic signed [WIDTH-1:0] r; int lat;
        do_op(-64, 0, r, lat);
        checks++; if (r !== -41'sd93) begin errors++; $display("FAIL neg_64 got %0d want -93", r); end
        do_op(5, 0, r, lat);
        checks++; if (r !== 41'sd6) begin errors++; $display("FAIL floor_5 got %0d want 6", r); end
    endtask

    task automatic test_program;
        logic signed [WIDTH-1:0] r; int lat;
        cfg_write(1, 0, 1'b1, 1'b0, 6'd0);
        cfg_write(1, 1, 1'b1, 1'b1, 6'd1);
        do_op(100, 1, r, lat);
        checks++; if (r !== 41'sd50) begin errors++; $display("FAIL set1_100 got %0d want 50", r); end
        do_op(7, 1, r, lat);
        checks++; if (r !== 41'sd4) begin errors++; $display("FAIL set1_7 got %0d want 4", r); end
        do_op(-1, 2, r, lat);
        checks++; if (r !== 41'sd0) begin errors++; $display("FAIL set2_empty got %0d want 0", r); end
    endtask

    task automatic test_hold;
        logic signed [WIDTH-1:0] r; int lat; int bad_v = 0; int bad_d = 0; int bad_r = 0;
        io.out_ready = 1'b0;
        do_op(64, 0, r, lat);
        io.in_valid = 1'b1; io.in_data = 5; io.in_sel = 0;
        for (int i = 0; i < 10; i++) begin
            if (io.out_valid !== 1'b1) bad_v++;
            if (io.out_data !== 41'sd93) bad_d++;
            if (io.in_ready !== 1'b0) bad_r++;
            step();
        end
        checks++; if (bad_v != 0) begin errors++; $display("FAIL hold_out_valid dropped %0d cycles want 0", bad_v); end
        checks++; if (bad_d != 0) begin errors++; $display("FAIL hold_out_data changed %0d cycles want 0", bad_d); end
        checks++; if (bad_r != 0) begin errors++; $display("FAIL hold_in_ready high %0d cycles want 0", bad_r); end
        io.out_ready = 1'b1;
        step();
        checks++; if (io.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL hold_release valid=%b busy=%b want 0/0", io.out_valid, busy); end
        step();
        checks++; if (busy !== 1'b1 || io.in_ready !== 1'b0) begin errors++; $display("FAIL hold_accept busy=%b in_ready=%b want 1/0", busy, io.in_ready); end
        io.in_valid = 1'b0;
        wait_result(r);
        checks++; if (r !== 41'sd6) begin errors++; $display("FAIL hold_next_result got %0d want 6", r); end
        step();
    endtask

    task automatic test_back_to_back;
        logic signed [WIDTH-1:0] r; int n = 0;
        io.in_valid = 1'b1; io.in_data = 64; io.in_sel = 0;
        step();
        while (busy && n < 50) begin step(); n++; end
        checks++; if (n !== 9) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 9", n); end
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept got busy=%b want 1", busy); end
        io.in_valid = 1'b0;
        wait_result(r);
        checks++; if (r !== 41'sd93) begin errors++; $display("FAIL b2b_result got %0d want 93", r); end
        step();
    endtask

    task automatic test_cfg_drop;
        logic signed [WIDTH-1:0] r; int lat;
        io.in_valid = 1'b1; io.in_data = 64; io.in_sel = 0;
        step();
        io.in_valid = 1'b0;
        cfg_write(0, 0, 1'b0, 1'b0, 6'd0);
        wait_result(r);
        step();
        checks++; if (r !== 41'sd93) begin errors++; $display("FAIL cfg_busy_result got %0d want 93", r); end
        io.in_valid = 1'b1; io.in_data = 64; io.in_sel = 0;
        cfg_we = 1'b1; cfg_sel = 0; cfg_term = 0; cfg_en = 1'b0; cfg_neg = 1'b0; cfg_shift = 0;
        step();
        io.in_valid = 1'b0; cfg_we = 1'b0;
        wait_result(r);
        step();
        checks++; if (r !== 41'sd93) begin errors++; $display("FAIL cfg_collide_result got %0d want 93", r); end
        do_op(64, 0, r, lat);
        checks++; if (r !== 41'sd93) begin errors++; $display("FAIL cfg_set0_unchanged got %0d want 93", r); end
    endtask

    task automatic test_overflow;
        logic signed [WIDTH-1:0] r; int lat;
        do_op(OVF_IN, 0, r, lat);
        checks++; if (r !== OVF_EXP) begin errors++; $display("FAIL overflow_wrap got %0d want %0d", r, OVF_EXP); end
    endtask

    task automatic test_reset_mid;
        logic signed [WIDTH-1:0] r; int lat;
        io.in_valid = 1'b1; io.in_data = 100; io.in_sel = 1;
        step();
        io.in_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #2;
        checks++; if (io.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset valid=%b busy=%b want 0/0", io.out_valid, busy); end
        checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %b want 1", io.in_ready); end
        step();
        rst_n = 1'b1;
        step();
        do_op(100, 1, r, lat);
        checks++; if (r !== 41'sd0) begin errors++; $display("FAIL midreset_set1_cleared got %0d want 0", r); end
        do_op(64, 0, r, lat);
        checks++; if (r !== 41'sd93) begin errors++; $display("FAIL midreset_set0_default got %0d want 93", r); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_floor();
        test_program();
        test_hold();
        test_back_to_back();
        test_cfg_drop();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
